fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin arbiter that shares the async FIFO write port among NUM_REQ write-domain requesters. Sits in the write clock domain in front of the write-pointer handler. Drives its w_en and write data, and uses its registered full flag for back-pressure. Each grant may be held for a burst of up to MAX_BURST beats before the port is released to the next requester.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- DATA_WIDTH, 8: FIFO word width.
- MAX_BURST, 4: maximum beats per grant, 1..16.
- w_clk  input  1  write-domain clock; all logic is on its rising edge.
- wrst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester write request.
- req_data  input  NUM_REQ*DATA_WIDTH  per-requester word; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  NUM_REQ  one-hot beat accept; high only for the granted requester, in the cycle its word is written.
- full  input  1  FIFO full, from the write-pointer handler.
- w_en  output  1  FIFO write enable.
- w_data  output  DATA_WIDTH  FIFO write data.
- grant_id  output  $clog2(NUM_REQ)  current or most recent grant owner.
- busy  output  1  high while in GRANT.

## Operation
- FSM states: IDLE, GRANT. Registers:
  - state
  - grant_id
  - last_grant
  - beat_cnt, $clog2(MAX_BURST)+1 bits
- IDLE:
  - If any req_valid is high, select the first valid index scanning last_grant+1, last_grant+2, … modulo NUM_REQ.
  - Load grant_id with that index, clear beat_cnt, go to GRANT.
  - If no req_valid is high, stay in IDLE.
- GRANT, beat accept:
  - beat = state==GRANT & req_valid[grant_id] & !full.
  - w_en = beat.
  - req_ready[grant_id] = beat; all other req_ready bits are 0.
  - w_data = req_data[grant_id] when beat, else 0.
- GRANT, counting: on each beat, beat_cnt increments.
- GRANT, release (last_grant <= grant_id, go to IDLE) when either:
  - a beat occurs with beat_cnt == MAX_BURST-1; or
  - req_valid[grant_id] is low.
- Full stall:
  - While full is high, the grant, beat_cnt and state hold.
  - No timeout; the owner keeps the port until full drops.
  - No beat is issued while full is high.
- Valid drop during a stall: if the owner deasserts req_valid while full is high, the grant is released anyway.
- Requester rule: req_data must be stable while req_valid & !req_ready. The arbiter does not check this.
- grant_id holds its last value in IDLE.
- Width rules:
  - The round-robin index wraps modulo NUM_REQ, including non-power-of-two values.
  - beat_cnt never exceeds MAX_BURST-1.

## Timing
- Reset values:
  - state = IDLE
  - grant_id = 0
  - last_grant = NUM_REQ-1, so requester 0 has first priority
  - beat_cnt = 0
  - w_en = 0, req_ready = 0, w_data = 0, busy = 0
- Reset asserted mid-burst: w_en and req_ready drop immediately (combinational from state), so no partial write occurs.
- Arbitration latency:
  - A request seen in IDLE at edge t gives state GRANT after edge t.
  - The first beat can be written at edge t+1.
- Turnaround: every release costs one IDLE bubble cycle before the next grant.
- Outputs: w_en, req_ready and w_data are combinational from registered state plus req_valid/full, with zero added latency.
- Full relation: full is sampled in the same cycle as w_en. A beat that fills the FIFO is written, and the next cycle sees full=1 and issues no beat.
- Simultaneous events:
  - A release condition and a new request from the same requester in the same cycle: the requester re-competes in IDLE with lowest priority.
  - If it is the only valid requester, it is re-granted.

## Configuration
- WR_ARB_BURST_EN, defined: burst lock as described; up to MAX_BURST beats per grant.
- WR_ARB_BURST_EN, undefined:
  - MAX_BURST is treated as 1; every grant releases after its first beat.
  - Each beat is followed by an IDLE bubble.
  - beat_cnt logic is removed.

## Test plan
- Reset, then req_valid=4'b0001 with 6 words, full=0 (burst enabled, MAX_BURST=4) -> beats 1-4 on consecutive cycles, one IDLE cycle, beats 5-6; req_ready only on bit 0.
- req_valid=4'b1111 held, full=0 -> grant order 0,1,2,3,0; each grant gets 4 beats and busy drops for one cycle between grants.
- Grant to requester 2, full rises after 2 beats for 5 cycles -> w_en=0 for 5 cycles, grant_id=2 held, remaining 2 beats issued after full falls, then release.
- Requester 1 deasserts req_valid after 1 beat -> release next edge, last_grant=1; next grant goes to requester 2 if valid.
- wrst pulsed mid-burst with full=0 -> w_en, req_ready and busy go 0 immediately; after release, requester 0 is granted first.
- WR_ARB_BURST_EN undefined, req_valid=4'b0011 -> alternating single beats 0,1,0,1 with one IDLE cycle between each.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle between the write-domain requesters and the round-robin FIFO write-port arbiter.
// The arbiter takes the slave modport; the requester/FIFO side takes the master modport.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          full;
    logic                          w_en;
    logic [DATA_WIDTH-1:0]         w_data;
    logic [ID_W-1:0]               grant_id;
    logic                          busy;

    modport master (
        output req_valid, req_data, full,
        input  req_ready, w_en, w_data, grant_id, busy
    );

    modport slave (
        input  req_valid, req_data, full,
        output req_ready, w_en, w_data, grant_id, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NUM_REQ requesters.
// Define WR_ARB_BURST_EN to let a grant hold the port for up to MAX_BURST beats.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic             w_clk,
    input  logic             wrst,
    fifo_wr_arbiter_if.slave bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          r_state;
    logic [ID_W-1:0] r_grant_id;
    logic [ID_W-1:0] r_last_grant;
`ifdef WR_ARB_BURST_EN
    logic [CNT_W-1:0] r_beat_cnt;
`endif

    logic [DATA_WIDTH-1:0] w_word [NUM_REQ];
    logic                  w_owner_valid;
    logic                  w_beat;
    logic                  w_last_beat;
    logic                  w_pick_found;
    logic [ID_W-1:0]       w_pick_id;
    logic [ID_W:0]         w_rr_sum;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign w_word[gi]        = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign bus.req_ready[gi] = w_beat && (r_grant_id == ID_W'(gi));
        end
    endgenerate

    assign w_owner_valid = bus.req_valid[r_grant_id];
    assign w_beat        = (r_state == GRANT) && w_owner_valid && !bus.full;
    assign bus.w_en      = w_beat;
    assign bus.w_data    = w_beat ? w_word[r_grant_id] : '0;
    assign bus.grant_id  = r_grant_id;
    assign bus.busy      = (r_state == GRANT);

`ifdef WR_ARB_BURST_EN
    assign w_last_beat = (r_beat_cnt == CNT_W'(MAX_BURST - 1));
`else
    assign w_last_beat = 1'b1;
`endif

    // Scan last_grant+1 .. last_grant+NUM_REQ; sum stays below 2*NUM_REQ so one wrap suffices.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_id    = '0;
        w_rr_sum     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_rr_sum = {1'b0, r_last_grant} + (ID_W+1)'(k);
            if (w_rr_sum >= (ID_W+1)'(NUM_REQ)) begin
                w_rr_sum = w_rr_sum - (ID_W+1)'(NUM_REQ);
            end
            if (!w_pick_found && bus.req_valid[w_rr_sum[ID_W-1:0]]) begin
                w_pick_found = 1'b1;
                w_pick_id    = w_rr_sum[ID_W-1:0];
            end
        end
    end

    always_ff @(posedge w_clk or posedge wrst) begin
        if (wrst) begin
            r_state      <= IDLE;
            r_grant_id   <= '0;
            r_last_grant <= ID_W'(NUM_REQ - 1);
`ifdef WR_ARB_BURST_EN
            r_beat_cnt   <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_found) begin
                        r_grant_id <= w_pick_id;
                        r_state    <= GRANT;
`ifdef WR_ARB_BURST_EN
                        r_beat_cnt <= '0;
`endif
                    end
                end
                GRANT: begin
                    // Owner dropping valid releases even while full stalls the port.
                    if (!w_owner_valid || (w_beat && w_last_beat)) begin
                        r_last_grant <= r_grant_id;
                        r_state      <= IDLE;
                    end
`ifdef WR_ARB_BURST_EN
                    else if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter; expectations follow the build (WR_ARB_BURST_EN or not).
module tb_fifo_wr_arbiter;
    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 8;
    localparam int MAX_BURST  = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) bus ();

    fifo_wr_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .MAX_BURST(MAX_BURST)
    ) dut (
        .w_clk (clk),
        .wrst  (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic en, input logic [3:0] rdy,
                           input logic [7:0] data, input logic [1:0] gid, input logic bsy);
        #1;
        chk({tag, ".w_en"},      32'(bus.w_en),      32'(en));
        chk({tag, ".req_ready"}, 32'(bus.req_ready), 32'(rdy));
        chk({tag, ".w_data"},    32'(bus.w_data),    32'(data));
        chk({tag, ".grant_id"},  32'(bus.grant_id),  32'(gid));
        chk({tag, ".busy"},      32'(bus.busy),      32'(bsy));
        $display("step %-14s w_en=%0b ready=%04b data=%02h gid=%0d busy=%0b",
                 tag, bus.w_en, bus.req_ready, bus.w_data, bus.grant_id, bus.busy);
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = {8'hD1, 8'hC1, 8'hB1, 8'hA1};
        bus.full      = 1'b0;
        tick();
        tick();
        chk_out("reset", 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0);
        rst = 1'b0;

`ifdef WR_ARB_BURST_EN
        bus.req_valid      = 4'b0001;
        bus.req_data[7:0]  = 8'h10;
        chk_out("idle_pre", 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0);
        tick();
        for (int k = 0; k < 4; k++) begin
            chk_out("burst", 1'b1, 4'b0001, 8'(8'h10 + k), 2'd0, 1'b1);
            bus.req_data[7:0] = 8'(8'h11 + k);
            tick();
        end
        chk_out("burst_bubble", 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0);
        tick();
        chk_out("burst_b5", 1'b1, 4'b0001, 8'h14, 2'd0, 1'b1);
        bus.req_data[7:0] = 8'h15;
        tick();
        chk_out("burst_b6", 1'b1, 4'b0001, 8'h15, 2'd0, 1'b1);
        bus.req_valid = 4'b0000;
        tick();
        chk_out("burst_rel", 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0);
        bus.req_valid = 4'b1000;
        tick();
        chk_out("burst_g3", 1'b1, 4'b1000, 8'hD1, 2'd3, 1'b1);
        rst = 1'b1;
        chk_out("rst_mid", 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0);
        tick();
        rst = 1'b0;
        bus.req_valid = 4'b1001;
        tick();
        chk_out("after_rst", 1'b1, 4'b0001, 8'h15, 2'd0, 1'b1);
        bus.req_valid = 4'b0000;
        tick();
`else
        bus.req_valid = 4'b0001;
        chk_out("idle_pre", 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0);
        tick();
        chk_out("single_b1", 1'b1, 4'b0001, 8'hA1, 2'd0, 1'b1);
        bus.req_data[7:0] = 8'hA2;
        tick();
        chk_out("bubble1", 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0);
        tick();
        chk_out("single_b2", 1'b1, 4'b0001, 8'hA2, 2'd0, 1'b1);
        bus.req_valid = 4'b0000;
        tick();
        chk_out("rel0", 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0);

        // last_grant is now 0, so the 0/1 pair alternates starting at 1
        bus.req_valid     = 4'b0011;
        bus.req_data[7:0] = 8'hA3;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] id;
            id = (i % 2 == 0) ? 2'd1 : 2'd0;
            tick();
            chk_out("rr_grant", 1'b1, 4'(1 << id), (id == 2'd1) ? 8'hB1 : 8'hA3, id, 1'b1);
            tick();
            chk_out("rr_bubble", 1'b0, 4'b0000, 8'h00, id, 1'b0);
        end
        bus.req_valid = 4'b0000;
        tick();

        bus.req_valid = 4'b0100;
        tick();
        bus.full = 1'b1;
        chk_out("stall", 1'b0, 4'b0000, 8'h00, 2'd2, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out("stall", 1'b0, 4'b0000, 8'h00, 2'd2, 1'b1);
        end
        bus.full = 1'b0;
        chk_out("stall_end", 1'b1, 4'b0100, 8'hC1, 2'd2, 1'b1);
        tick();
        chk_out("post_stall", 1'b0, 4'b0000, 8'h00, 2'd2, 1'b0);

        bus.req_valid = 4'b0010;
        bus.full      = 1'b1;
        tick();
        chk_out("drop_grant", 1'b0, 4'b0000, 8'h00, 2'd1, 1'b1);
        bus.req_valid = 4'b0100;
        chk_out("drop_nobeat", 1'b0, 4'b0000, 8'h00, 2'd1, 1'b1);
        tick();
        chk_out("drop_rel", 1'b0, 4'b0000, 8'h00, 2'd1, 1'b0);
        bus.full = 1'b0;
        tick();
        chk_out("next2", 1'b1, 4'b0100, 8'hC1, 2'd2, 1'b1);

        bus.req_valid = 4'b1000;
        chk_out("owner_drop", 1'b0, 4'b0000, 8'h00, 2'd2, 1'b1);
        tick();
        chk_out("idle2", 1'b0, 4'b0000, 8'h00, 2'd2, 1'b0);
        tick();
        chk_out("g3", 1'b1, 4'b1000, 8'hD1, 2'd3, 1'b1);

        rst = 1'b1;
        chk_out("rst_mid", 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0);
        tick();
        rst = 1'b0;
        bus.req_valid = 4'b1001;
        chk_out("rst_idle", 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0);
        tick();
        chk_out("after_rst", 1'b1, 4'b0001, 8'hA3, 2'd0, 1'b1);

        bus.req_valid = 4'b0001;
        tick();
        chk_out("solo_rel", 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0);
        tick();
        chk_out("solo_regrant", 1'b1, 4'b0001, 8'hA3, 2'd0, 1'b1);
        bus.req_valid = 4'b0000;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
